// File: rtl/sld_pkg.sv
// Shared types for the sliding-window detector stream scheduler.
// State encoding and requester ids.
package sld_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DRAIN = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/sld_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment.
module sld_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/sld_stream_sched.sv
// Round-robin scheduler sharing one sliding-window detector
// between two word requesters; owns detector reset and hit counts.
module sld_stream_sched
    import sld_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DRAIN = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             clr,
    input  logic             dec1,
    input  logic             dec2,
    output logic             ack0,
    output logic             ack1,
    output logic             det_in,
    output logic             det_rst_n,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] hit1_0,
    output logic [CNT_W-1:0] hit2_0,
    output logic [CNT_W-1:0] hit1_1,
    output logic [CNT_W-1:0] hit2_1
);

    localparam int CW = $clog2(WIDTH + 16);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             owner, owner_n;
    logic             last_grant, lg_n;
    logic             ack0_n, ack1_n;
    logic             drst_n_n, busy_n;
    logic             done_n, done_id_n;
    logic             cnt_clr;
    logic             gid;
    logic             active;

    // det_in is the shift register MSB; it drains to zero by itself
    assign det_in = shreg[WIDTH-1];

    always_comb begin
        gid = REQ0;
        unique case ({req1, req0})
            2'b01:   gid = REQ0;
            2'b10:   gid = REQ1;
            2'b11:   gid = ~last_grant;
            default: gid = REQ0;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = '0;
        owner_n   = owner;
        lg_n      = last_grant;
        ack0_n    = 1'b0;
        ack1_n    = 1'b0;
        drst_n_n  = 1'b1;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (clr) begin
                    state_n  = S_CLEAR;
                    cnt_n    = '0;
                    drst_n_n = 1'b0;
                    busy_n   = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (req0 || req1) begin
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                    shreg_n = gid ? data1 : data0;
                    owner_n = gid;
                    lg_n    = gid;
                    ack0_n  = (gid == REQ0);
                    ack1_n  = (gid == REQ1);
                    busy_n  = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_n  = 1'b1;
                shreg_n = {shreg[WIDTH-2:0], 1'b0};
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                    done_n  = (DRAIN == 1);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == CW'(DRAIN - 1)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    busy_n = 1'b1;
                    cnt_n  = cnt + CW'(1);
                    done_n = (cnt_n == CW'(DRAIN - 1));
                end
            end
            S_CLEAR: begin
                cnt_clr = 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    busy_n   = 1'b1;
                    drst_n_n = 1'b0;
                    cnt_n    = CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        done_id_n = done_n & owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            owner      <= REQ0;
            last_grant <= REQ1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            det_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            owner      <= owner_n;
            last_grant <= lg_n;
            ack0       <= ack0_n;
            ack1       <= ack1_n;
            det_rst_n  <= drst_n_n;
            busy       <= busy_n;
            done       <= done_n;
            done_id    <= done_id_n;
        end
    end

    assign active = (state == S_SHIFT) || (state == S_DRAIN);

    sld_sat_cnt #(.CNT_W(CNT_W)) u_h1_0 (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr),
        .inc(active && dec1 && (owner == REQ0)), .q(hit1_0)
    );
    sld_sat_cnt #(.CNT_W(CNT_W)) u_h2_0 (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr),
        .inc(active && dec2 && (owner == REQ0)), .q(hit2_0)
    );
    sld_sat_cnt #(.CNT_W(CNT_W)) u_h1_1 (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr),
        .inc(active && dec1 && (owner == REQ1)), .q(hit1_1)
    );
    sld_sat_cnt #(.CNT_W(CNT_W)) u_h2_1 (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr),
        .inc(active && dec2 && (owner == REQ1)), .q(hit2_1)
    );

endmodule
